// File: rtl/cdc_pkg.sv
// Shared constants and types for the toggle req/ack clock-domain-crossing blocks.
package cdc_pkg;

  localparam int CDC_SYNC_STAGES_DEFAULT = 2;

  // Implicit handshake state: FREE when the synchronised ack has caught up with req.
  typedef enum logic {
    HS_FREE = 1'b0,
    HS_BUSY = 1'b1
  } hs_state_e;

endpackage

// File: rtl/cdc_export_fifo_if.sv
// Producer-side and crossing-side signals of the export FIFO, bundled with master/slave views.
interface cdc_export_fifo_if #(
  parameter int pBits  = 8,
  parameter int pDepth = 4
);

  localparam int CW = $clog2(pDepth + 1);

  // Producer handshake: a word transfers on any clock edge where stb=1 and ready=1;
  // stb with ready=0 is ignored. ready depends only on registered state.
  // Crossing: cdc_data is stable whenever cdc_req != cdc_ack; a new word is offered by toggling cdc_req.
  logic             stb;
  logic [pBits-1:0] data;
  logic             ready;
  logic [CW-1:0]    count;
  logic             idle;
  logic             cdc_req;
  logic [pBits-1:0] cdc_data;
  logic             cdc_ack;

  modport master (
    output stb, data, cdc_ack,
    input  ready, count, idle, cdc_req, cdc_data
  );

  modport slave (
    input  stb, data, cdc_ack,
    output ready, count, idle, cdc_req, cdc_data
  );

endinterface

// File: rtl/cdc_sync_bit.sv
// N-flop synchroniser for a single asynchronous bit; output is the last stage.
module cdc_sync_bit #(
  parameter int pStages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [pStages-1:0] sync_q;
  logic [pStages-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[pStages-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[pStages-1];

endmodule

// File: rtl/cdc_export_fifo.sv
// Sending half of a toggle req/ack crossing with a local FIFO so the producer can
// queue several words while earlier ones are still in flight.
module cdc_export_fifo
  import cdc_pkg::*;
#(
  parameter int pBits       = 8,
  parameter int pDepth      = 4,
  parameter int pSyncStages = CDC_SYNC_STAGES_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  cdc_export_fifo_if.slave bus,
  output hs_state_e dbg_hs_state
);

  localparam int AW = $clog2(pDepth);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(pDepth + 1);

  logic [pBits-1:0] mem_q [pDepth];
  logic [pBits-1:0] mem_d [pDepth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             cdc_req_q, cdc_req_d;
  logic [pBits-1:0] cdc_data_q, cdc_data_d;

  logic          ack_sync;
  logic          hs_free;
  logic          full;
  logic          empty;
  logic          push;
  logic          launch;
  logic [PW-1:0] fill;

  cdc_sync_bit #(.pStages(pSyncStages)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.cdc_ack),
    .q   (ack_sync)
  );

  always_comb begin
    fill    = wr_ptr_q - rd_ptr_q;
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    hs_free = (ack_sync == cdc_req_q);
    // Full is judged on registered pointers only, so a same-edge launch never frees a slot early.
    push    = bus.stb && !full;
    launch  = hs_free && !empty;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cdc_req_d  = cdc_req_q;
    cdc_data_d = cdc_data_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = bus.data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (launch) begin
      cdc_data_d = mem_q[rd_ptr_q[AW-1:0]];
      cdc_req_d  = !cdc_req_q;
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cdc_req_q  <= 1'b0;
      cdc_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cdc_req_q  <= cdc_req_d;
      cdc_data_q <= cdc_data_d;
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.ready    = !full;
  assign bus.count    = CW'(fill);
  assign bus.idle     = empty && hs_free;
  assign bus.cdc_req  = cdc_req_q;
  assign bus.cdc_data = cdc_data_q;
  assign dbg_hs_state = hs_free ? HS_FREE : HS_BUSY;

`ifndef SYNTHESIS
  a_data_stable_while_busy : assert property (
    @(posedge clk) disable iff (rst) (cdc_req_q != ack_sync) |=> $stable(cdc_data_q)
  );
  a_no_back_to_back_launch : assert property (
    @(posedge clk) disable iff (rst) launch |=> !launch
  );
`endif

endmodule

// File: tb/tb_cdc_export_fifo.sv
// Bench for cdc_export_fifo: directed vector table, wrap/reset sequences and a two-configuration soak.
module tb_cdc_export_fifo;
  import cdc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdc_export_fifo_if #(.pBits(8),  .pDepth(4)) bus0 ();
  cdc_export_fifo_if #(.pBits(32), .pDepth(8)) bus1 ();
  hs_state_e dbg0, dbg1;

  cdc_export_fifo #(.pBits(8), .pDepth(4), .pSyncStages(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_hs_state(dbg0)
  );
  cdc_export_fifo #(.pBits(32), .pDepth(8), .pSyncStages(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_hs_state(dbg1)
  );

  int total = 0;
  int bad   = 0;

  // Responder models for the receiving side.
  logic tb_ack0 = 1'b0, resp_ack0 = 1'b0, resp_ack1 = 1'b0;
  bit   resp_en0 = 1'b0;
  bit   last_req0 = 1'b0, pend0 = 1'b0, last_req1 = 1'b0, pend1 = 1'b0;
  int   cnt0 = 0, cnt1 = 0, dmin0 = 0, dmax0 = 0;
  logic [7:0]  exp0_q[$], rx0_q[$];
  logic [31:0] exp1_q[$], rx1_q[$];

  assign bus0.cdc_ack = resp_en0 ? resp_ack0 : tb_ack0;
  assign bus1.cdc_ack = resp_ack1;

  always @(posedge clk) begin
    #2;
    if (rst || !resp_en0) begin
      last_req0 = rst ? 1'b0 : bus0.cdc_req;
      resp_ack0 = rst ? 1'b0 : tb_ack0;
      pend0     = 1'b0;
    end else begin
      if (!pend0 && bus0.cdc_req != last_req0) begin
        last_req0 = bus0.cdc_req;
        rx0_q.push_back(bus0.cdc_data);
        pend0 = 1'b1;
        cnt0  = $urandom_range(dmax0, dmin0);
      end
      if (pend0) begin
        if (cnt0 == 0) begin
          resp_ack0 = last_req0;
          pend0     = 1'b0;
        end else cnt0--;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst) begin
      last_req1 = 1'b0;
      resp_ack1 = 1'b0;
      pend1     = 1'b0;
    end else begin
      if (!pend1 && bus1.cdc_req != last_req1) begin
        last_req1 = bus1.cdc_req;
        rx1_q.push_back(bus1.cdc_data);
        pend1 = 1'b1;
        cnt1  = $urandom_range(7, 0);
      end
      if (pend1) begin
        if (cnt1 == 0) begin
          resp_ack1 = last_req1;
          pend1     = 1'b0;
        end else cnt1--;
      end
    end
  end

  typedef struct {
    logic       rst;
    logic       stb;
    logic [7:0] data;
    logic       ack;
    logic       exp_req;
    logic [7:0] exp_data;
    logic       exp_ready;
    logic [2:0] exp_count;
    logic       exp_idle;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(int r, int s, int d, int a, int er, int ed, int erd, int ec, int ei);
    vec_t v;
    v.rst = r[0]; v.stb = s[0]; v.data = d[7:0]; v.ack = a[0];
    v.exp_req = er[0]; v.exp_data = ed[7:0]; v.exp_ready = erd[0];
    v.exp_count = ec[2:0]; v.exp_idle = ei[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push0(input logic [7:0] w);
    int n = 0;
    while (!bus0.ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!bus0.ready) begin
      chk("push0 ready timeout", 32'(bus0.ready), 32'd1);
    end else begin
      bus0.stb = 1'b1; bus0.data = w;
      exp0_q.push_back(w);
      @(posedge clk); #1;
      bus0.stb = 1'b0;
    end
  endtask

  task automatic push1(input logic [31:0] w);
    int n = 0;
    while (!bus1.ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!bus1.ready) begin
      chk("push1 ready timeout", 32'(bus1.ready), 32'd1);
    end else begin
      bus1.stb = 1'b1; bus1.data = w;
      exp1_q.push_back(w);
      @(posedge clk); #1;
      bus1.stb = 1'b0;
    end
  endtask

  task automatic drain_and_compare(input string name);
    int n = 0;
    while (n < 2000 && !(rx0_q.size() >= exp0_q.size() && bus0.idle &&
                         rx1_q.size() >= exp1_q.size() && bus1.idle)) begin
      @(posedge clk); #1; n++;
    end
    chk({name, " drain idle0"}, 32'(bus0.idle), 32'd1);
    chk({name, " drain idle1"}, 32'(bus1.idle), 32'd1);
    chk({name, " rx0 size"}, rx0_q.size(), exp0_q.size());
    chk({name, " rx1 size"}, rx1_q.size(), exp1_q.size());
    for (int i = 0; i < exp0_q.size() && i < rx0_q.size(); i++)
      chk($sformatf("%s w0[%0d]", name, i), 32'(rx0_q[i]), 32'(exp0_q[i]));
    for (int i = 0; i < exp1_q.size() && i < rx1_q.size(); i++)
      chk($sformatf("%s w1[%0d]", name, i), rx1_q[i], exp1_q[i]);
    exp0_q.delete(); rx0_q.delete(); exp1_q.delete(); rx1_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.stb = 1'b0; bus0.data = '0;
    bus1.stb = 1'b0; bus1.data = '0;

    // rst stb data ack | req data ready count idle
    vecs[0]  = mk(1,1,'hFF,0, 0,'h00,1,0,1);
    vecs[1]  = mk(1,1,'hFF,0, 0,'h00,1,0,1);
    vecs[2]  = mk(1,1,'hFF,0, 0,'h00,1,0,1);
    vecs[3]  = mk(0,0,'h00,0, 0,'h00,1,0,1);
    vecs[4]  = mk(0,1,'hA5,0, 0,'h00,1,1,0);
    vecs[5]  = mk(0,0,'h00,0, 1,'hA5,1,0,0);
    vecs[6]  = mk(0,0,'h00,0, 1,'hA5,1,0,0);
    vecs[7]  = mk(0,0,'h00,0, 1,'hA5,1,0,0);
    vecs[8]  = mk(0,0,'h00,1, 1,'hA5,1,0,0);
    vecs[9]  = mk(0,0,'h00,1, 1,'hA5,1,0,1);
    vecs[10] = mk(0,1,'h01,1, 1,'hA5,1,1,0);
    vecs[11] = mk(0,1,'h02,1, 0,'h01,1,1,0);
    vecs[12] = mk(0,1,'h03,1, 0,'h01,1,2,0);
    vecs[13] = mk(0,1,'h04,1, 0,'h01,1,3,0);
    vecs[14] = mk(0,1,'h05,1, 0,'h01,0,4,0);
    vecs[15] = mk(0,1,'h06,1, 0,'h01,0,4,0);
    vecs[16] = mk(0,0,'h00,0, 0,'h01,0,4,0);
    vecs[17] = mk(0,0,'h00,0, 0,'h01,0,4,0);
    vecs[18] = mk(0,0,'h00,0, 1,'h02,1,3,0);
    vecs[19] = mk(0,0,'h00,1, 1,'h02,1,3,0);
    vecs[20] = mk(0,0,'h00,1, 1,'h02,1,3,0);
    vecs[21] = mk(0,0,'h00,1, 0,'h03,1,2,0);
    vecs[22] = mk(0,0,'h00,0, 0,'h03,1,2,0);
    vecs[23] = mk(0,0,'h00,0, 0,'h03,1,2,0);
    vecs[24] = mk(0,1,'h07,0, 1,'h04,1,2,0);
    vecs[25] = mk(0,0,'h00,1, 1,'h04,1,2,0);
    vecs[26] = mk(0,0,'h00,1, 1,'h04,1,2,0);
    vecs[27] = mk(0,0,'h00,1, 0,'h05,1,1,0);
    vecs[28] = mk(0,0,'h00,0, 0,'h05,1,1,0);
    vecs[29] = mk(0,0,'h00,0, 0,'h05,1,1,0);
    vecs[30] = mk(0,0,'h00,0, 1,'h07,1,0,0);
    vecs[31] = mk(0,0,'h00,1, 1,'h07,1,0,0);
    vecs[32] = mk(0,0,'h00,1, 1,'h07,1,0,1);

    for (int i = 0; i < 33; i++) begin
      rst       = vecs[i].rst;
      bus0.stb  = vecs[i].stb;
      bus0.data = vecs[i].data;
      tb_ack0   = vecs[i].ack;
      @(posedge clk); #1;
      chk($sformatf("v%0d req", i),   32'(bus0.cdc_req),  32'(vecs[i].exp_req));
      chk($sformatf("v%0d data", i),  32'(bus0.cdc_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d ready", i), 32'(bus0.ready),    32'(vecs[i].exp_ready));
      chk($sformatf("v%0d count", i), 32'(bus0.count),    32'(vecs[i].exp_count));
      chk($sformatf("v%0d idle", i),  32'(bus0.idle),     32'(vecs[i].exp_idle));
    end
    bus0.stb = 1'b0;

    // Pointer wrap: 13 words through a 4-deep FIFO with a one-cycle responder.
    dmin0 = 1; dmax0 = 1;
    resp_en0 = 1'b1;
    for (int w = 0; w < 13; w++) push0(8'h30 + 8'(w));
    drain_and_compare("wrap");

    // Asynchronous reset with one word in flight and three buffered.
    tb_ack0  = resp_ack0;
    resp_en0 = 1'b0;
    for (int w = 0; w < 4; w++) begin
      bus0.stb = 1'b1; bus0.data = 8'hC0 + 8'(w);
      @(posedge clk); #1;
    end
    bus0.stb = 1'b0;
    chk("pre-reset count", 32'(bus0.count), 32'd3);
    chk("pre-reset req", 32'(bus0.cdc_req), 32'd1);
    chk("pre-reset data", 32'(bus0.cdc_data), 32'hC0);
    chk("pre-reset ready", 32'(bus0.ready), 32'd1);
    #2;
    rst = 1'b1;
    tb_ack0 = 1'b0;
    #1;
    chk("async rst req", 32'(bus0.cdc_req), 32'd0);
    chk("async rst count", 32'(bus0.count), 32'd0);
    chk("async rst ready", 32'(bus0.ready), 32'd1);
    chk("async rst data", 32'(bus0.cdc_data), 32'd0);
    chk("async rst idle", 32'(bus0.idle), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp0_q.delete(); rx0_q.delete(); exp1_q.delete(); rx1_q.delete();

    // Soak both configurations with random gaps and responder delays.
    dmin0 = 0; dmax0 = 7;
    resp_en0 = 1'b1;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
          push0(8'($urandom_range(255, 0)));
        end
      end
      begin
        for (int k = 0; k < 1000; k++) begin
          repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
          push1($urandom());
        end
      end
    join
    drain_and_compare("soak");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_export_fifo.md
Name: cdc_export_fifo

Overview:
Source half of the toggle req/ack clock-domain-crossing handshake, extended with a local FIFO so the producer can queue several words without waiting for each round trip.
- Words accepted on stb/ready are buffered, then launched one at a time onto cdc_data/cdc_req.
- Each launch waits until the synchronised cdc_ack has caught up with cdc_req.
- Sits in the sending clock domain, paired with the existing import-side block in the receiving domain.

Parameters:
pBits, 8, width of each transferred word
pDepth, 4, FIFO entries; power of two, >= 2
pSyncStages, 2, flip-flop stages on cdc_ack; >= 2

Ports:
clk  in  1  sending-domain clock
rst  in  1  asynchronous, active-high reset
stb  in  1  one-cycle strobe: enqueue data; honoured only when ready=1
data  in  pBits  word to enqueue
ready  out  1  FIFO not full (count != pDepth)
count  out  $clog2(pDepth+1)  words buffered, excluding the in-flight word
idle  out  1  FIFO empty and no handshake outstanding
cdc_req  out  1  toggle request to the receiving domain, registered
cdc_data  out  pBits  word presented to the receiving domain, registered
cdc_ack  in  1  toggle acknowledge from the receiving domain, asynchronous

Behaviour:
- Reset is asynchronous, active-high. While rst=1: cdc_req=0, cdc_data=0, FIFO empty (pointers=0, count=0), all sync flops=0. Consequently ready=1 and idle=1.
- ack_sync is the last stage of a pSyncStages-deep synchroniser on cdc_ack. No other logic samples cdc_ack.
- hs_free = (ack_sync == cdc_req).
- Push: stb && ready writes data at the write pointer and increments it. stb with ready=0 is ignored; the FIFO is not modified.
- Launch:
  - Condition: hs_free && count != 0, evaluated at a clock edge.
  - Action: cdc_data <= head word, cdc_req <= !cdc_req, read pointer increments.
  - Throughput: at most one launch per round trip.
  - Launch data is a registered FIFO read with no bypass. A word pushed into an empty, free FIFO at edge N appears on cdc_data/cdc_req at edge N+1.
- cdc_data is held stable from launch until the next launch. This guarantees it is stable whenever req != ack.
- Simultaneous push and launch: both happen and count is unchanged. When full, ready=0 even if a launch occurs on the same edge. The decision is conservative, with no combinational path from the handshake to ready.
- Pointers are $clog2(pDepth)+1 bits with natural wrap-around. Full = MSBs differ and the rest are equal. Empty = pointers equal.
- idle = (count == 0) && hs_free.
- Handshake states (implicit, derived from cdc_req and ack_sync):
  - FREE (equal): may launch.
  - BUSY (differ): waits for ack_sync to match.
  - After a launch, BUSY lasts at least pSyncStages cycles, so a double launch is impossible.
- Reset mid-transfer discards buffered and in-flight words. The system reset scheme must reset the receiving side in the same window; this block does not recover a lost toggle.
- Word order at the receiver equals push order. No loss or duplication outside reset.

Decomposition:
- Package cdc_pkg:
  - constant CDC_SYNC_STAGES_DEFAULT = 2.
  - typedef enum {HS_FREE, HS_BUSY}, used for assertions and debug only.
- One sub-module: cdc_sync_bit (pStages parameter; clk, rst, d, q), an N-flop synchroniser reused by the import side.
- The FIFO storage and pointers stay inline.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with stb=1 -> cdc_req=0, cdc_data=0, ready=1, count=0, idle=1 throughout. stb is ignored.
2. Single word: push 0xA5; the responder model echoes req into cdc_ack 3 cycles later -> cdc_data=0xA5 and cdc_req=1 one edge after stb, count returns to 0, idle=1 pSyncStages edges after ack toggles.
3. Stalled receiver (pDepth=4), ack held at 0, push 0x01..0x06 back-to-back:
   - 0x01 launches.
   - 0x02..0x05 buffer and count=4; ready=0 after the 0x05 push.
   - 0x06 is dropped.
   - Release the responder -> receiver captures 01,02,03,04,05 in order.
4. Push and launch on the same edge (count=2, ack arriving) -> count stays 2, the new word lands at the tail, and ordering is preserved across pointer wrap (run 3*pDepth words).
5. Reset mid-transfer: assert rst while cdc_req=1, ack pending, count=3 -> cdc_req=0, count=0, ready=1 immediately (asynchronous, before the next edge).
6. Soak: 1000 random words with random stb gaps and a random responder delay of 0-7 cycles, plus pBits=32, pDepth=8, pSyncStages=3 -> scoreboard shows an exact in-order match. An assertion checks cdc_data never changes while cdc_req != ack_sync.
